instr_encoder_loader: RTL

- Writer-side counterpart of the CPU instruction decoder.
- Accepts symbolic instruction fields (opcode, Rd, Rs1, Rs2, imm) over a valid/ready handshake and packs them into 16-bit instruction words.
- Writes the words sequentially into instruction memory from a base address, so the CPU fetch/decode path can execute the program after the load completes.
- Sits between the host/UART front end and the instruction ROM/RAM write port.

---
 rtl/cpu_isa_pkg.sv | 31 +++
 rtl/instr_encoder_loader_if.sv | 29 ++
 rtl/instr_packer.sv | 28 ++
 rtl/instr_encoder_loader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared CPU ISA definitions: opcodes, field widths and the loader FSM state type.
// Imported by the instruction loader, its packer and the CPU decoder.
package cpu_isa_pkg;

  localparam int OP_W    = 4;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_BEQ = 4'h2,
    OP_BGT = 4'h3,
    OP_BLT = 4'h4,
    OP_B   = 4'h5,
    OP_MOV = 4'h6,
    OP_LDR = 4'h7,
    OP_LSL = 4'h8,
    OP_STR = 4'h9,
    OP_NEG = 4'hA
  } opcode_e;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_ACCEPT,
    LD_WRITE,
    LD_DONE
  } loader_state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake plus instruction-memory write port of the loader.
interface instr_encoder_loader_if
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_op;
  logic [REG_W-1:0]   in_rd;
  logic [REG_W-1:0]   in_rs1;
  logic [REG_W-1:0]   in_rs2;
  logic [IMM_W-1:0]   in_imm;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_packer.sv
// Combinational encoder: symbolic instruction fields to a 16-bit word plus legality flag.
module instr_packer
  import cpu_isa_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   rd,
  input  logic [REG_W-1:0]   rs1,
  input  logic [REG_W-1:0]   rs2,
  input  logic [IMM_W-1:0]   imm,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD, OP_SUB:               word = {op, rd, rs1, rs2};
      OP_NEG:                       word = {op, rd, 4'h0, rs2};
      OP_BEQ, OP_BGT, OP_BLT, OP_B: word = {op, imm, 4'h0};
      OP_MOV, OP_LSL:               word = {op, rd, imm};
      // Load/store offsets are only 4 bits wide; imm[7:4] is dropped.
      OP_LDR, OP_STR:               word = {op, rd, rs1, imm[3:0]};
      default:                      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs field bundles into instruction words and writes them sequentially from address 0.
// Optional INSTR_LOADER_CHECKSUM_EN adds a running XOR of all written words.
module instr_encoder_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                finish,
  instr_encoder_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic                overflow,
  output logic [ADDR_W:0]     word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_W-1:0]  checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  loader_state_e      state;
  logic [ADDR_W:0]    cnt;
  logic               fin_pend;
  logic               we_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [INSTR_W-1:0] wdata_p1;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_legal;
  logic               take;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum_r;
`endif

  instr_packer u_packer (
    .op    (bus.in_op),
    .rd    (bus.in_rd),
    .rs1   (bus.in_rs1),
    .rs2   (bus.in_rs2),
    .imm   (bus.in_imm),
    .word  (pk_word),
    .legal (pk_legal)
  );

  assign take = (state == LD_ACCEPT) && bus.in_valid;

  // Stage p0 -> p1: handshake registers the packed word; WRITE cycle presents it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LD_IDLE;
      cnt         <= '0;
      fin_pend    <= 1'b0;
      we_p1       <= 1'b0;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      err_illegal <= 1'b0;
      overflow    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_r       <= '0;
`endif
    end else begin
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
      case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            state       <= LD_ACCEPT;
            cnt         <= '0;
            fin_pend    <= 1'b0;
            addr_p1     <= '0;
            err_illegal <= 1'b0;
            overflow    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_r       <= '0;
`endif
          end
        end
        LD_ACCEPT: begin
          if (take) begin
            if (cnt == DEPTH_L) begin
              overflow <= 1'b1;
              state    <= LD_DONE;
            end else begin
              state    <= LD_WRITE;
              fin_pend <= finish;
              if (pk_legal) begin
                we_p1    <= 1'b1;
                addr_p1  <= cnt[ADDR_W-1:0];
                wdata_p1 <= pk_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
                sum_r    <= sum_r ^ pk_word;
`endif
              end else begin
                err_illegal <= 1'b1;
              end
            end
          end else if (finish) begin
            state <= LD_DONE;
          end
        end
        LD_WRITE: begin
          // Illegal bundles pass through WRITE without advancing the address.
          if (we_p1) cnt <= cnt + ONE_L;
          fin_pend <= 1'b0;
          state    <= (fin_pend || finish) ? LD_DONE : LD_ACCEPT;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  // Reset suppresses a pending write strobe in the very cycle it is raised.
  assign bus.mem_we    = we_p1 && !reset;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;
  assign bus.in_ready  = (state == LD_ACCEPT);
  assign busy          = (state == LD_ACCEPT) || (state == LD_WRITE);
  assign done          = (state == LD_DONE);
  assign word_count    = cnt;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum      = sum_r;
`endif

endmodule
